// File: rtl/sha256_stream_padder.sv
// sha256_stream_padder
// Front end for the SHA-256 datapath. Accepts a message as a valid/ready
// stream of IN_BYTES bytes per beat and emits a one-byte-per-cycle stream
// carrying the message, the 0x80 marker, zero fill and the 64-bit
// big-endian bit length, framed into 64-byte blocks.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_data              message bytes, first byte in the MSBs
//   in_valid/in_ready    input beat handshake
//   in_last, in_bytes    final beat marker and its valid byte count
//   out_byte             padded stream byte
//   out_valid/out_ready  output byte handshake
//   out_sob/out_eob      byte index 0 / 63 of a block
//   out_first/out_last   first block / final block of a message
module sha256_stream_padder #(
  parameter int IN_BYTES = 1,
  parameter int LEN_W    = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [8*IN_BYTES-1:0]     in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [$clog2(IN_BYTES):0] in_bytes,
  output logic                      in_ready,
  output logic [7:0]                out_byte,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sob,
  output logic                      out_eob,
  output logic                      out_first,
  output logic                      out_last
);

  localparam int BW = $clog2(IN_BYTES) + 1;
  localparam int DW = 8 * IN_BYTES;

  typedef enum logic [1:0] {
    S_MSG   = 2'd0,
    S_PAD80 = 2'd1,
    S_ZERO  = 2'd2,
    S_LEN   = 2'd3
  } state_t;

  state_t           state_r, state_n_s;
  logic [DW-1:0]    buf_r, buf_n_s;
  logic [BW-1:0]    cnt_r, cnt_n_s;
  logic [5:0]       idx_r, idx_n_s;
  logic [LEN_W-1:0] msg_bits_r, msg_bits_n_s;
  logic             first_flag_r, first_flag_n_s;
  logic             last_pending_r, last_pending_n_s;

  logic             in_ready_s;
  logic             xfer_s;
  logic             load_s;

  logic [7:0]       out_byte_r, out_byte_n_s;
  logic             out_valid_r, out_valid_n_s;
  logic             out_sob_r, out_sob_n_s;
  logic             out_eob_r, out_eob_n_s;
  logic             out_first_r, out_first_n_s;
  logic             out_last_r, out_last_n_s;
  logic [63:0]      len64_s;
  logic [63:0]      len_shift_s;

  assign out_byte  = out_byte_r;
  assign out_valid = out_valid_r;
  assign out_sob   = out_sob_r;
  assign out_eob   = out_eob_r;
  assign out_first = out_first_r;
  assign out_last  = out_last_r;
  assign in_ready  = in_ready_s;

  assign xfer_s = out_valid_r & out_ready;
  assign load_s = in_valid & in_ready_s;

  // Input acceptance: empty buffer, or last buffered byte leaving this cycle
  // (the second case keeps 1 byte/cycle when IN_BYTES = 1).
  always_comb begin
    in_ready_s = 1'b0;
    if (reset) begin
      in_ready_s = 1'b0;
    end else if ((state_r == S_MSG) && !last_pending_r) begin
      if (cnt_r == {BW{1'b0}}) begin
        in_ready_s = 1'b1;
      end else if ((cnt_r == BW'(1)) && out_ready) begin
        in_ready_s = 1'b1;
      end else begin
        in_ready_s = 1'b0;
      end
    end else begin
      in_ready_s = 1'b0;
    end
  end

  // Next-state logic for the FSM, holding buffer, block index and length.
  always_comb begin
    state_n_s        = state_r;
    buf_n_s          = buf_r;
    cnt_n_s          = cnt_r;
    idx_n_s          = idx_r;
    msg_bits_n_s     = msg_bits_r;
    first_flag_n_s   = first_flag_r;
    last_pending_n_s = last_pending_r;

    if (xfer_s) begin
      idx_n_s        = idx_r + 6'd1;
      first_flag_n_s = 1'b0;
    end else begin
      idx_n_s        = idx_r;
    end

    case (state_r)
      S_MSG: begin
        if (xfer_s) begin
          buf_n_s      = buf_r << 8;
          cnt_n_s      = cnt_r - BW'(1);
          msg_bits_n_s = msg_bits_r + LEN_W'(8);
        end else begin
          buf_n_s      = buf_r;
        end
        // A load on the same cycle as a transfer overrides the shift.
        if (load_s) begin
          buf_n_s          = in_data;
          cnt_n_s          = in_last ? in_bytes : BW'(IN_BYTES);
          last_pending_n_s = in_last;
        end else begin
          last_pending_n_s = last_pending_r;
        end
        // Final message byte gone (or empty last beat): start padding.
        if (last_pending_n_s && (cnt_n_s == {BW{1'b0}})) begin
          state_n_s        = S_PAD80;
          last_pending_n_s = 1'b0;
        end else begin
          state_n_s        = S_MSG;
        end
      end
      S_PAD80: begin
        if (xfer_s) begin
          state_n_s = (idx_n_s == 6'd56) ? S_LEN : S_ZERO;
        end else begin
          state_n_s = S_PAD80;
        end
      end
      S_ZERO: begin
        if (xfer_s && (idx_n_s == 6'd56)) begin
          state_n_s = S_LEN;
        end else begin
          state_n_s = S_ZERO;
        end
      end
      S_LEN: begin
        if (xfer_s && (idx_r == 6'd63)) begin
          state_n_s        = S_MSG;
          buf_n_s          = {DW{1'b0}};
          cnt_n_s          = {BW{1'b0}};
          idx_n_s          = 6'd0;
          msg_bits_n_s     = {LEN_W{1'b0}};
          first_flag_n_s   = 1'b1;
          last_pending_n_s = 1'b0;
        end else begin
          state_n_s        = S_LEN;
        end
      end
      default: begin
        state_n_s = S_MSG;
      end
    endcase
  end

  // Output values derived from the next state so that every output is a
  // flop and holds stable through a stall.
  always_comb begin
    len64_s     = 64'(msg_bits_n_s);
    // Length bytes go out MSB first: index 56 carries bits 63:56.
    len_shift_s = len64_s >> {3'd7 - idx_n_s[2:0], 3'b000};
    case (state_n_s)
      S_MSG: begin
        out_valid_n_s = (cnt_n_s != {BW{1'b0}});
        out_byte_n_s  = out_valid_n_s ? buf_n_s[DW-1 -: 8] : 8'h00;
      end
      S_PAD80: begin
        out_valid_n_s = 1'b1;
        out_byte_n_s  = 8'h80;
      end
      S_ZERO: begin
        out_valid_n_s = 1'b1;
        out_byte_n_s  = 8'h00;
      end
      S_LEN: begin
        out_valid_n_s = 1'b1;
        out_byte_n_s  = len_shift_s[7:0];
      end
      default: begin
        out_valid_n_s = 1'b0;
        out_byte_n_s  = 8'h00;
      end
    endcase
    out_sob_n_s   = out_valid_n_s & (idx_n_s == 6'd0);
    out_eob_n_s   = out_valid_n_s & (idx_n_s == 6'd63);
    out_first_n_s = out_sob_n_s & first_flag_n_s;
    out_last_n_s  = out_eob_n_s & (state_n_s == S_LEN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= S_MSG;
      buf_r          <= {DW{1'b0}};
      cnt_r          <= {BW{1'b0}};
      idx_r          <= 6'd0;
      msg_bits_r     <= {LEN_W{1'b0}};
      first_flag_r   <= 1'b1;
      last_pending_r <= 1'b0;
      out_byte_r     <= 8'h00;
      out_valid_r    <= 1'b0;
      out_sob_r      <= 1'b0;
      out_eob_r      <= 1'b0;
      out_first_r    <= 1'b0;
      out_last_r     <= 1'b0;
    end else begin
      state_r        <= state_n_s;
      buf_r          <= buf_n_s;
      cnt_r          <= cnt_n_s;
      idx_r          <= idx_n_s;
      msg_bits_r     <= msg_bits_n_s;
      first_flag_r   <= first_flag_n_s;
      last_pending_r <= last_pending_n_s;
      out_byte_r     <= out_byte_n_s;
      out_valid_r    <= out_valid_n_s;
      out_sob_r      <= out_sob_n_s;
      out_eob_r      <= out_eob_n_s;
      out_first_r    <= out_first_n_s;
      out_last_r     <= out_last_n_s;
    end
  end

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Directed bench for sha256_stream_padder: one IN_BYTES=1 instance and one
// IN_BYTES=4 instance, sharing clock and reset.
module tb_sha256_stream_padder;

  logic       clk;
  logic       reset;

  logic [7:0] in1_data;
  logic       in1_valid, in1_last, in1_ready;
  logic [0:0] in1_bytes;
  logic [7:0] out1_byte;
  logic       out1_valid, out1_ready, out1_sob, out1_eob, out1_first, out1_last;

  logic [31:0] in4_data;
  logic        in4_valid, in4_last, in4_ready;
  logic [2:0]  in4_bytes;
  logic [7:0]  out4_byte;
  logic        out4_valid, out4_ready, out4_sob, out4_eob, out4_first, out4_last;

  int checks = 0;
  int errors = 0;

  logic [7:0] msg [0:255];
  int         msg_len;
  logic [7:0] cap_b [0:255];
  logic [3:0] cap_f [0:255];
  int         cap_n;
  int         first_acc, last_xfer;
  int         stall_seen, stall_err;
  logic       timed_out;

  sha256_stream_padder #(.IN_BYTES(1), .LEN_W(64)) u_dut1 (
    .clk(clk), .reset(reset),
    .in_data(in1_data), .in_valid(in1_valid), .in_last(in1_last), .in_bytes(in1_bytes),
    .in_ready(in1_ready), .out_byte(out1_byte), .out_valid(out1_valid), .out_ready(out1_ready),
    .out_sob(out1_sob), .out_eob(out1_eob), .out_first(out1_first), .out_last(out1_last)
  );

  sha256_stream_padder #(.IN_BYTES(4), .LEN_W(64)) u_dut4 (
    .clk(clk), .reset(reset),
    .in_data(in4_data), .in_valid(in4_valid), .in_last(in4_last), .in_bytes(in4_bytes),
    .in_ready(in4_ready), .out_byte(out4_byte), .out_valid(out4_valid), .out_ready(out4_ready),
    .out_sob(out4_sob), .out_eob(out4_eob), .out_first(out4_first), .out_last(out4_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference padding: message, 0x80, zeros, 64-bit big-endian bit count.
  function automatic logic [7:0] exp_byte(input int i, input int total);
    logic [63:0] bits;
    bits = 64'(msg_len) << 3;
    if (i < msg_len) return msg[i];
    else if (i == msg_len) return 8'h80;
    else if (i >= total - 8) begin
      bits = bits >> (8 * (total - 1 - i));
      return bits[7:0];
    end
    else return 8'h00;
  endfunction

  // Expected {sob, eob, first, last} for byte i of a total-byte padded message.
  function automatic logic [3:0] exp_flags(input int i, input int total);
    return {(i % 64) == 0, (i % 64) == 63, i == 0, i == total - 1};
  endfunction

  task automatic set_msg_fill(input int len, input logic [7:0] v);
    for (int k = 0; k < 256; k++) msg[k] = (k < len) ? v : 8'h00;
    msg_len = len;
  endtask

  // Drive one message into the selected instance and capture output bytes
  // until stop_at bytes are taken or the cycle budget runs out.
  // mode 0: out_ready held high; mode 1: out_ready toggles 1,0,1,0...
  task automatic run_msg(input int sel, input int mode, input int stop_at);
    int   ptr, nbeats, cyc;
    logic ordy, v, irdy, ival;
    logic [7:0] b, held_b;
    logic [3:0] f, held_f;
    logic held_v;
    nbeats = (msg_len == 0) ? 1 : ((sel == 1) ? msg_len : (msg_len + 3) / 4);
    cap_n = 0; first_acc = -1; last_xfer = -1; stall_seen = 0; stall_err = 0;
    timed_out = 1'b0; held_v = 1'b0; held_b = 8'h00; held_f = 4'h0; ptr = 0; cyc = 0;
    while ((cap_n < stop_at) && !timed_out) begin
      @(negedge clk);
      ordy = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      ival = (ptr < nbeats);
      if (sel == 1) begin
        out1_ready = ordy;
        in1_valid  = ival;
        in1_data   = ival ? msg[ptr] : 8'h00;
        in1_last   = (ptr == nbeats - 1);
        in1_bytes  = (msg_len == 0) ? 1'b0 : 1'b1;
      end else begin
        out4_ready = ordy;
        in4_valid  = ival;
        in4_data   = ival ? {msg[4*ptr], msg[4*ptr+1], msg[4*ptr+2], msg[4*ptr+3]} : 32'h0;
        in4_last   = (ptr == nbeats - 1);
        in4_bytes  = (ptr == nbeats - 1) ? 3'(msg_len - 4 * (nbeats - 1)) : 3'd4;
      end
      #1;
      v    = (sel == 1) ? out1_valid : out4_valid;
      irdy = (sel == 1) ? in1_ready : in4_ready;
      b    = (sel == 1) ? out1_byte : out4_byte;
      f    = (sel == 1) ? {out1_sob, out1_eob, out1_first, out1_last}
                        : {out4_sob, out4_eob, out4_first, out4_last};
      if (held_v && (!v || (b !== held_b) || (f !== held_f))) stall_err++;
      held_v = 1'b0;
      if (v && ordy) begin
        cap_b[cap_n] = b; cap_f[cap_n] = f; cap_n++; last_xfer = cyc;
      end else if (v) begin
        held_v = 1'b1; held_b = b; held_f = f; stall_seen++;
      end
      if (ival && irdy) begin
        ptr++;
        if (first_acc < 0) first_acc = cyc;
      end
      cyc++;
      if (cyc >= 2000) timed_out = 1'b1;
    end
    in1_valid = 1'b0; in4_valid = 1'b0;
    out1_ready = 1'b1; out4_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in1_ready, in4_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_in_ready got %b expected 00", {in1_ready, in4_ready});
    end
    checks++;
    if ({out1_valid, out1_byte, out1_sob, out1_eob, out1_first, out1_last} !== 13'h0) begin
      errors++; $display("FAIL reset_out1 got %b/%h expected 0/00", out1_valid, out1_byte);
    end
    checks++;
    if ({out4_valid, out4_byte, out4_sob, out4_eob, out4_first, out4_last} !== 13'h0) begin
      errors++; $display("FAIL reset_out4 got %b/%h expected 0/00", out4_valid, out4_byte);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in1_ready, in4_ready} !== 2'b11) begin
      errors++; $display("FAIL post_reset_in_ready got %b expected 11", {in1_ready, in4_ready});
    end
  endtask

  task automatic test_abc;
    set_msg_fill(3, 8'h00);
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg(1, 0, 64);
    checks++;
    if (timed_out !== 1'b0 || cap_n !== 64) begin
      errors++; $display("FAIL abc_count got %0d expected 64", cap_n);
    end
    for (int i = 0; i < cap_n; i++) begin
      checks++;
      if ({cap_b[i], cap_f[i]} !== {exp_byte(i, 64), exp_flags(i, 64)}) begin
        errors++;
        $display("FAIL abc_byte%0d got %h/%b expected %h/%b", i, cap_b[i], cap_f[i],
                 exp_byte(i, 64), exp_flags(i, 64));
      end
    end
    checks++;
    if (cap_b[3] !== 8'h80 || cap_b[63] !== 8'h18) begin
      errors++; $display("FAIL abc_pad got %h %h expected 80 18", cap_b[3], cap_b[63]);
    end
    checks++;
    if (last_xfer - first_acc + 1 !== 65) begin
      errors++; $display("FAIL abc_cycles got %0d expected 65", last_xfer - first_acc + 1);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (out1_valid !== 1'b0) begin
      errors++; $display("FAIL abc_extra got %b expected 0", out1_valid);
    end
  endtask

  task automatic test_empty;
    set_msg_fill(0, 8'h00);
    run_msg(1, 0, 64);
    checks++;
    if (timed_out !== 1'b0 || cap_n !== 64) begin
      errors++; $display("FAIL empty_count got %0d expected 64", cap_n);
    end
    for (int i = 0; i < cap_n; i++) begin
      checks++;
      if ({cap_b[i], cap_f[i]} !== {exp_byte(i, 64), exp_flags(i, 64)}) begin
        errors++;
        $display("FAIL empty_byte%0d got %h/%b expected %h/%b", i, cap_b[i], cap_f[i],
                 exp_byte(i, 64), exp_flags(i, 64));
      end
    end
    checks++;
    if ({cap_b[0], cap_f[0], cap_f[63]} !== {8'h80, 4'b1010, 4'b0101}) begin
      errors++; $display("FAIL empty_frame got %h %b %b expected 80 1010 0101",
                         cap_b[0], cap_f[0], cap_f[63]);
    end
  endtask

  task automatic test_55_bytes;
    set_msg_fill(55, 8'hAA);
    run_msg(1, 0, 64);
    checks++;
    if (timed_out !== 1'b0 || cap_n !== 64) begin
      errors++; $display("FAIL m55_count got %0d expected 64", cap_n);
    end
    for (int i = 0; i < cap_n; i++) begin
      checks++;
      if ({cap_b[i], cap_f[i]} !== {exp_byte(i, 64), exp_flags(i, 64)}) begin
        errors++;
        $display("FAIL m55_byte%0d got %h/%b expected %h/%b", i, cap_b[i], cap_f[i],
                 exp_byte(i, 64), exp_flags(i, 64));
      end
    end
    checks++;
    if ({cap_b[55], cap_b[62], cap_b[63]} !== {8'h80, 8'h01, 8'hB8}) begin
      errors++; $display("FAIL m55_len got %h %h %h expected 80 01 b8",
                         cap_b[55], cap_b[62], cap_b[63]);
    end
  endtask

  task automatic test_56_bytes;
    set_msg_fill(56, 8'h5C);
    run_msg(1, 0, 128);
    checks++;
    if (timed_out !== 1'b0 || cap_n !== 128) begin
      errors++; $display("FAIL m56_count got %0d expected 128", cap_n);
    end
    for (int i = 0; i < cap_n; i++) begin
      checks++;
      if ({cap_b[i], cap_f[i]} !== {exp_byte(i, 128), exp_flags(i, 128)}) begin
        errors++;
        $display("FAIL m56_byte%0d got %h/%b expected %h/%b", i, cap_b[i], cap_f[i],
                 exp_byte(i, 128), exp_flags(i, 128));
      end
    end
    checks++;
    if ({cap_f[63], cap_f[64], cap_f[127]} !== {4'b0100, 4'b1000, 4'b0101}) begin
      errors++; $display("FAIL m56_flags got %b %b %b expected 0100 1000 0101",
                         cap_f[63], cap_f[64], cap_f[127]);
    end
    checks++;
    if ({cap_b[56], cap_b[126], cap_b[127]} !== {8'h80, 8'h01, 8'hC0}) begin
      errors++; $display("FAIL m56_len got %h %h %h expected 80 01 c0",
                         cap_b[56], cap_b[126], cap_b[127]);
    end
  endtask

  task automatic test_in4_stall;
    set_msg_fill(5, 8'h00);
    for (int k = 0; k < 5; k++) msg[k] = 8'(k + 1);
    run_msg(4, 1, 64);
    checks++;
    if (timed_out !== 1'b0 || cap_n !== 64) begin
      errors++; $display("FAIL in4_count got %0d expected 64", cap_n);
    end
    for (int i = 0; i < cap_n; i++) begin
      checks++;
      if ({cap_b[i], cap_f[i]} !== {exp_byte(i, 64), exp_flags(i, 64)}) begin
        errors++;
        $display("FAIL in4_byte%0d got %h/%b expected %h/%b", i, cap_b[i], cap_f[i],
                 exp_byte(i, 64), exp_flags(i, 64));
      end
    end
    checks++;
    if ({cap_b[4], cap_b[5], cap_b[63]} !== {8'h05, 8'h80, 8'h28}) begin
      errors++; $display("FAIL in4_pad got %h %h %h expected 05 80 28",
                         cap_b[4], cap_b[5], cap_b[63]);
    end
    checks++;
    if (stall_seen == 0 || stall_err != 0) begin
      errors++; $display("FAIL in4_stall got seen=%0d bad=%0d expected seen>0 bad=0",
                         stall_seen, stall_err);
    end
  endtask

  task automatic test_reset_mid;
    set_msg_fill(10, 8'h3C);
    run_msg(1, 0, 3);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out1_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_valid got %b expected 0", out1_valid);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out1_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_stale got %b expected 0", out1_valid);
    end
    set_msg_fill(3, 8'h00);
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg(1, 0, 64);
    checks++;
    if (timed_out !== 1'b0 || cap_n !== 64) begin
      errors++; $display("FAIL rst_abc_count got %0d expected 64", cap_n);
    end
    for (int i = 0; i < cap_n; i++) begin
      checks++;
      if ({cap_b[i], cap_f[i]} !== {exp_byte(i, 64), exp_flags(i, 64)}) begin
        errors++;
        $display("FAIL rst_abc_byte%0d got %h/%b expected %h/%b", i, cap_b[i], cap_f[i],
                 exp_byte(i, 64), exp_flags(i, 64));
      end
    end
    checks++;
    if (cap_b[63] !== 8'h18) begin
      errors++; $display("FAIL rst_abc_len got %h expected 18", cap_b[63]);
    end
  endtask

  initial begin
    reset = 1'b1;
    in1_data = 8'h00; in1_valid = 1'b0; in1_last = 1'b0; in1_bytes = 1'b0; out1_ready = 1'b1;
    in4_data = 32'h0; in4_valid = 1'b0; in4_last = 1'b0; in4_bytes = 3'd0; out4_ready = 1'b1;
    msg_len = 0;
    test_reset;
    test_abc;
    test_empty;
    test_55_bytes;
    test_56_bytes;
    test_in4_stall;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
